// File: rtl/irq_arbiter_if.sv
// rtl/irq_arbiter_if.sv - CPU strobe/address and device interrupt signals of the interrupt arbiter
interface irq_arbiter_if #(
    parameter int DBITS = 32,
    parameter int NIRQ  = 4
);
    logic             ld;
    logic             sw;
    logic [DBITS-1:0] addrbus;
    logic [NIRQ-1:0]  irq_in;
    logic             intack;
    logic             intr;

    modport master (
        output ld, sw, addrbus, irq_in, intack,
        input  intr
    );

    modport slave (
        input  ld, sw, addrbus, irq_in, intack,
        output intr
    );
endinterface

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - round-robin interrupt arbiter with ack timeout and memory-mapped registers
module irq_arbiter #(
    parameter int          DBITS       = 32,
    parameter int          NIRQ        = 4,
    parameter int          ACK_TIMEOUT = 16,
    parameter logic [31:0] IRQENADDR   = 32'hFFFFF200,
    parameter logic [31:0] IRQSTATADDR = 32'hFFFFF204,
    parameter logic [31:0] IRQCURADDR  = 32'hFFFFF208,
    parameter logic [31:0] IRQTOUTADDR = 32'hFFFFF20C
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [DBITS-1:0] databus,
    irq_arbiter_if.slave     bus
);
    localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;
    localparam int CW = $clog2(ACK_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_intr;
    logic [NIRQ-1:0] r_irqen;
    logic            r_tout;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_cur;
    logic [IW-1:0]   r_lastid;

    logic [NIRQ-1:0] w_active;
    logic            w_any;
    logic            w_found;
    logic [IW-1:0]   w_grant;
    logic [IW-1:0]   w_sel;
    int              w_idx;

    logic            w_hit_en;
    logic            w_hit_stat;
    logic            w_hit_cur;
    logic            w_hit_tout;
    logic            w_rd_en;
    logic [31:0]     w_rd32;
    logic            w_unused;

    assign w_active = bus.irq_in & r_irqen;
    assign w_any    = |w_active;

    // Search starts just after the last granted id so every source gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_grant = r_lastid;
        w_idx   = 0;
        w_sel   = '0;
        for (int k = 1; k <= NIRQ; k++) begin
            w_idx = (int'(r_lastid) + k) % NIRQ;
            w_sel = IW'(w_idx);
            if (!w_found && w_active[w_sel]) begin
                w_found = 1'b1;
                w_grant = w_sel;
            end
        end
    end

    assign w_hit_en   = (bus.addrbus == DBITS'(IRQENADDR));
    assign w_hit_stat = (bus.addrbus == DBITS'(IRQSTATADDR));
    assign w_hit_cur  = (bus.addrbus == DBITS'(IRQCURADDR));
    assign w_hit_tout = (bus.addrbus == DBITS'(IRQTOUTADDR));
    assign w_rd_en    = bus.ld && (w_hit_en || w_hit_stat || w_hit_cur || w_hit_tout);

    always_comb begin
        w_rd32 = 32'd0;
        if (w_hit_en)
            w_rd32 = 32'(r_irqen);
        else if (w_hit_stat)
            w_rd32 = 32'(w_active);
        else if (w_hit_cur)
            w_rd32 = {(r_state != S_IDLE), 31'(r_cur)};
        else if (w_hit_tout)
            w_rd32 = {31'd0, r_tout};
    end

    assign databus  = w_rd_en ? DBITS'(w_rd32) : {DBITS{1'bz}};
    assign bus.intr = r_intr;
    assign w_unused = ^databus;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_intr   <= 1'b0;
            r_irqen  <= '0;
            r_tout   <= 1'b0;
            r_cnt    <= '0;
            r_cur    <= '0;
            r_lastid <= IW'(NIRQ - 1);
        end else begin
            if (bus.sw && w_hit_en)
                r_irqen <= databus[NIRQ-1:0];
            if (bus.sw && w_hit_tout && !databus[0])
                r_tout <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_cur    <= w_grant;
                        r_lastid <= w_grant;
                        r_cnt    <= '0;
                        r_intr   <= 1'b1;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Acknowledge takes priority over an expiring wait counter.
                    if (bus.intack) begin
                        r_cnt   <= '0;
                        r_intr  <= 1'b0;
                        r_state <= S_SERVICE;
                    end else if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
                        r_cnt   <= '0;
                        r_intr  <= 1'b0;
                        r_tout  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SERVICE: begin
                    if (bus.sw && w_hit_cur)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_intr  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_irq_arbiter.sv
// tb/tb_irq_arbiter.sv - directed self-checking bench for irq_arbiter
module tb_irq_arbiter;
    localparam logic [31:0] A_EN   = 32'hFFFFF200;
    localparam logic [31:0] A_STAT = 32'hFFFFF204;
    localparam logic [31:0] A_CUR  = 32'hFFFFF208;
    localparam logic [31:0] A_TOUT = 32'hFFFFF20C;

    logic        clk;
    logic        reset;
    logic        drv_en;
    logic [31:0] drv_data;
    logic [31:0] rd;
    wire  [31:0] databus;
    int          n_total;
    int          n_bad;

    irq_arbiter_if #(.DBITS(32), .NIRQ(4)) bus ();

    irq_arbiter #(.DBITS(32), .NIRQ(4), .ACK_TIMEOUT(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .databus (databus),
        .bus     (bus)
    );

    // An undriven bus reads as all ones.
    pullup (databus);
    assign databus = drv_en ? drv_data : 32'hzzzzzzzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input logic [31:0] addr, output logic [31:0] data);
        bus.ld      = 1'b1;
        bus.addrbus = addr;
        #1;
        data        = databus;
        bus.ld      = 1'b0;
        bus.addrbus = 32'd0;
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
        bus.sw      = 1'b1;
        bus.addrbus = addr;
        drv_en      = 1'b1;
        drv_data    = data;
        step();
        bus.sw      = 1'b0;
        bus.addrbus = 32'd0;
        drv_en      = 1'b0;
    endtask

    task automatic ack_eoi();
        bus.intack = 1'b1;
        step();
        bus.intack = 1'b0;
        cpu_write(A_CUR, 32'd0);
    endtask

    initial begin
        logic [31:0] exp_id[4];
        n_total     = 0;
        n_bad       = 0;
        reset       = 1'b1;
        drv_en      = 1'b0;
        drv_data    = 32'd0;
        bus.ld      = 1'b0;
        bus.sw      = 1'b0;
        bus.addrbus = 32'd0;
        bus.irq_in  = 4'b0000;
        bus.intack  = 1'b0;
        repeat (2) step();
        reset = 1'b0;

        check("rst_intr", {31'd0, bus.intr}, 32'd0);
        cpu_read(A_EN, rd);   check("rst_irqen", rd, 32'd0);
        cpu_read(A_CUR, rd);  check("rst_cur", rd, 32'd0);
        cpu_read(A_TOUT, rd); check("rst_tout", rd, 32'd0);

        bus.addrbus = A_EN;
        #1 check("z_ld0", databus, 32'hFFFFFFFF);
        cpu_read(32'hFFFFF210, rd); check("z_unmapped", rd, 32'hFFFFFFFF);

        cpu_write(A_EN, 32'h1);
        check("idle_intr", {31'd0, bus.intr}, 32'd0);
        bus.irq_in = 4'b0001;
        step();
        check("lat_intr", {31'd0, bus.intr}, 32'd1);
        cpu_read(A_CUR, rd);  check("lat_cur", rd, 32'h80000000);
        cpu_read(A_STAT, rd); check("stat", rd, 32'h1);
        cpu_write(A_STAT, 32'h0);
        cpu_read(A_STAT, rd); check("stat_ro", rd, 32'h1);
        bus.intack = 1'b1;
        step();
        bus.intack = 1'b0;
        check("svc_intr", {31'd0, bus.intr}, 32'd0);
        cpu_read(A_CUR, rd); check("svc_cur", rd, 32'h80000000);
        cpu_write(A_CUR, 32'd0);
        check("eoi_intr", {31'd0, bus.intr}, 32'd0);
        step();
        check("relevel_intr", {31'd0, bus.intr}, 32'd1);
        bus.irq_in = 4'b0000;
        ack_eoi();

        reset = 1'b1;
        #1 reset = 1'b0;
        cpu_write(A_EN, 32'hF);
        bus.irq_in = 4'b0101;
        exp_id = '{32'h80000000, 32'h80000002, 32'h80000000, 32'h80000002};
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_intr", {31'd0, bus.intr}, 32'd1);
            cpu_read(A_CUR, rd); check("rr_cur", rd, exp_id[i]);
            ack_eoi();
        end
        bus.irq_in = 4'b0000;

        bus.irq_in = 4'b0011;
        step();
        cpu_read(A_CUR, rd); check("to_grant", rd, 32'h80000000);
        repeat (15) step();
        check("to_wait", {31'd0, bus.intr}, 32'd1);
        step();
        check("to_intr", {31'd0, bus.intr}, 32'd0);
        cpu_read(A_TOUT, rd); check("to_flag", rd, 32'd1);
        cpu_read(A_CUR, rd);  check("to_idle", rd, 32'h00000000);
        step();
        cpu_read(A_CUR, rd);  check("to_skip", rd, 32'h80000001);
        cpu_write(A_TOUT, 32'd1);
        cpu_read(A_TOUT, rd); check("to_keep", rd, 32'd1);
        cpu_write(A_TOUT, 32'd0);
        cpu_read(A_TOUT, rd); check("to_clear", rd, 32'd0);
        bus.intack = 1'b1;
        step();
        bus.intack = 1'b0;
        bus.irq_in = 4'b0000;
        cpu_write(A_CUR, 32'd0);

        bus.irq_in = 4'b0001;
        step();
        repeat (15) step();
        bus.intack = 1'b1;
        step();
        bus.intack = 1'b0;
        check("lastack_intr", {31'd0, bus.intr}, 32'd0);
        cpu_read(A_CUR, rd);  check("lastack_cur", rd, 32'h80000000);
        cpu_read(A_TOUT, rd); check("lastack_tout", rd, 32'd0);

        bus.irq_in = 4'b0000;
        cpu_write(A_CUR, 32'd0);
        cpu_read(A_CUR, rd); check("eoi_idle", rd, 32'h00000000);
        cpu_write(A_CUR, 32'd0);
        cpu_read(A_CUR, rd); check("eoi_in_idle", rd, 32'h00000000);
        check("eoi_in_idle_intr", {31'd0, bus.intr}, 32'd0);

        bus.irq_in = 4'b0100;
        step();
        cpu_read(A_CUR, rd); check("g2_cur", rd, 32'h80000002);
        cpu_write(A_CUR, 32'd0);
        check("eoi_in_req", {31'd0, bus.intr}, 32'd1);
        cpu_write(A_EN, 32'h0);
        check("en_clr_req", {31'd0, bus.intr}, 32'd1);
        cpu_read(A_EN, rd); check("en_clr_val", rd, 32'h0);
        bus.intack = 1'b1;
        step();
        bus.intack = 1'b0;
        cpu_read(A_CUR, rd); check("en_clr_svc", rd, 32'h80000002);

        cpu_write(A_EN, 32'hF);
        reset = 1'b1;
        #1;
        cpu_read(A_EN, rd);  check("rst_svc_en", rd, 32'h0);
        cpu_read(A_CUR, rd); check("rst_svc_cur", rd, 32'h0);
        check("rst_svc_intr", {31'd0, bus.intr}, 32'd0);
        reset = 1'b0;

        cpu_write(A_EN, 32'hF);
        step();
        check("req2_intr", {31'd0, bus.intr}, 32'd1);
        cpu_read(A_CUR, rd); check("req2_cur", rd, 32'h80000002);
        reset = 1'b1;
        #1 check("rst_req_intr", {31'd0, bus.intr}, 32'd0);
        reset = 1'b0;
        bus.irq_in = 4'b0000;
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter DBITS, default 32, SHALL set the width of the data and address buses.
REQ-002 Parameter NIRQ, default 4, SHALL set the number of device interrupt inputs (2..8).
REQ-003 Parameter ACK_TIMEOUT, default 16, SHALL set the cycles allowed for CPU acknowledge.
REQ-004 Parameters IRQENADDR=32'hFFFFF200, IRQSTATADDR=32'hFFFFF204, IRQCURADDR=32'hFFFFF208, IRQTOUTADDR=32'hFFFFF20C SHALL set register addresses.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 ld  input  1  CPU load strobe.
REQ-008 sw  input  1  CPU store strobe.
REQ-009 addrbus  input  DBITS  CPU address.
REQ-010 databus  inout  DBITS  shared data bus.
REQ-011 irq_in  input  NIRQ  level interrupt requests from devices, e.g. the timer TIMERIRQ.
REQ-012 intack  input  1  CPU interrupt acknowledge, one or more cycles high.
REQ-013 intr  output  NIRQ-independent 1  registered interrupt request to the CPU.

Function
REQ-014 Registers: IRQEN (NIRQ bits, R/W), IRQSTAT (read-only, irq_in & IRQEN), IRQCUR (read: bit31 busy, low bits current id; write: end-of-interrupt), IRQTOUT (bit0 sticky timeout flag).
REQ-015 databus SHALL be driven, zero-extended, only while ld=1 and addrbus matches one of the four addresses; otherwise all bits SHALL be high-impedance.
REQ-016 A store to IRQEN SHALL load databus[NIRQ-1:0] on the next edge in any state.
REQ-017 A store to IRQTOUT with databus[0]=0 SHALL clear the timeout flag; a store with databus[0]=1 SHALL leave it unchanged.
REQ-018 Stores to IRQSTAT SHALL be ignored.
REQ-019 The FSM SHALL have three states: IDLE, REQ, SERVICE.
REQ-020 IDLE: when active = irq_in & IRQEN is nonzero, the block SHALL grant one source, latch its id into cur, set lastid to that id, and move to REQ on the next edge.
REQ-021 Grant SHALL be round-robin: the first active index in the order lastid+1, lastid+2, ..., modulo NIRQ.
REQ-022 REQ: intr SHALL be 1; a wait counter SHALL count cycles from 0.
REQ-023 REQ with intack=1 SHALL move to SERVICE on the next edge and clear the counter.
REQ-024 REQ with intack=0 and counter = ACK_TIMEOUT-1 SHALL move to IDLE, set the timeout flag, and keep lastid so the next grant skips that source.
REQ-025 If intack=1 in the final timeout cycle, the acknowledge SHALL win and no timeout SHALL be flagged.
REQ-026 SERVICE: intr SHALL be 0; any store to IRQCURADDR SHALL return to IDLE on the next edge.
REQ-027 EOI stores in IDLE or REQ SHALL be ignored.
REQ-028 Clearing an IRQEN bit while its source is in REQ or SERVICE SHALL NOT cancel the grant.
REQ-029 IRQCUR bit31 SHALL read 1 in REQ and SERVICE and 0 in IDLE; the id field SHALL hold the last granted id.
REQ-030 A level still asserted after EOI SHALL be re-arbitrated; there SHALL be no edge detection.
REQ-031 Minimum latency from an active source in IDLE to intr=1 SHALL be one cycle.

Reset
REQ-032 Reset SHALL force state to IDLE, intr to 0, IRQEN to 0, the timeout flag to 0, the counter to 0, cur to 0, and lastid to NIRQ-1, so that the first grant searches from index 0.
REQ-033 Reset asserted mid-REQ or mid-SERVICE SHALL abort immediately, without waiting for a clock edge.

Verification
REQ-034 IRQEN=4'b1111, irq_in=4'b0101 held, ack and EOI on each grant -> grants SHALL be 0, 2, 0, 2 in that order.
REQ-035 IRQEN=4'b0001, irq_in[0] rises -> intr=1 one edge later; a read of IRQCURADDR SHALL return 32'h80000000.
REQ-036 In REQ, intack held 0 for 16 cycles -> IDLE with intr=0; a read of IRQTOUTADDR SHALL return 1; a store of 0 SHALL then clear it to 0.
REQ-037 intack=1 exactly on the 16th REQ cycle -> SERVICE, with the IRQTOUT read still returning 0.
REQ-038 EOI stored in IDLE -> no state change; reset pulsed in SERVICE -> intr=0 and IRQEN=0 immediately.
REQ-039 ld=0, or an unmapped address -> databus SHALL read all Z.
